// File: rtl/ultrasonic_sensor_ascii_converter_pkg.sv
// Shared constants for the ASCII-to-integer decoder: character codes,
// FSM state encodings and default parameter values.
package ultrasonic_sensor_ascii_converter_pkg;

  localparam int value_width_default_p = 9;
  localparam int max_digits_default_p  = 3;

  localparam logic [7:0] ascii_zero_p = 8'h30;
  localparam logic [7:0] ascii_nine_p = 8'h39;
  localparam logic [7:0] ascii_cr_p   = 8'h0D;
  localparam logic [7:0] ascii_lf_p   = 8'h0A;

  localparam logic [1:0] fsm_idle_p    = 2'd0;
  localparam logic [1:0] fsm_mul_p     = 2'd1;
  localparam logic [1:0] fsm_add_p     = 2'd2;
  localparam logic [1:0] fsm_discard_p = 2'd3;

  typedef enum logic [1:0] {
    st_idle    = fsm_idle_p,
    st_mul     = fsm_mul_p,
    st_add     = fsm_add_p,
    st_discard = fsm_discard_p
  } fsm_state_e;

endpackage

// File: rtl/ultrasonic_sensor_ascii_converter_classifier.sv
// Combinational character classifier: splits an ASCII byte into
// digit / terminator flags and the binary digit value.
module ascii_char_classifier
  import ultrasonic_sensor_ascii_converter_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] digit
);

  // Digit codes 0x30..0x39 carry their value in the low nibble.
  always_comb begin
    is_digit = (data >= ascii_zero_p) && (data <= ascii_nine_p);
    is_term  = (data == ascii_cr_p) || (data == ascii_lf_p);
    digit    = data[3:0];
  end

endmodule

// File: rtl/ultrasonic_sensor_ascii_converter.sv
// ASCII decimal string to binary integer decoder. Each digit is folded in
// over three cycles (accept, multiply-by-ten via shift-add, add digit), so
// no multiplier or divider is needed.
module ultrasonic_sensor_ascii_converter
  import ultrasonic_sensor_ascii_converter_pkg::*;
#(
  parameter int value_width_p = value_width_default_p,
  parameter int max_digits_p  = max_digits_default_p
) (
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic [7:0]               Data_i,
  input  logic                     Data_Available_i,
  output logic                     Ready_o,
  output logic [value_width_p-1:0] Value_o,
  output logic                     Value_Available_o,
  output logic                     Error_o
);

  localparam int ext_w = value_width_p + 4;
  localparam int cnt_w = $clog2(max_digits_p + 1);

  // acc * 10 as (acc << 3) + (acc << 1), widened so it cannot wrap.
  function automatic logic [ext_w-1:0] times_ten(input logic [value_width_p-1:0] a);
    logic [ext_w-1:0] e;
    e = ext_w'(a);
    return (e << 3) + (e << 1);
  endfunction

  // True when the widened sum no longer fits in the result width.
  function automatic logic exceeds_range(input logic [ext_w-1:0] v);
    return |v[ext_w-1:value_width_p];
  endfunction

  fsm_state_e               state_q, state_d;
  logic [value_width_p-1:0] acc_q, acc_d;
  logic [cnt_w-1:0]         count_q, count_d;
  logic [3:0]               digit_p0, digit_p0_d;
  logic [ext_w-1:0]         acc_ext_p1, acc_ext_p1_d;
  logic [value_width_p-1:0] value_q, value_d;
  logic                     value_vld_q, value_vld_d;
  logic                     error_q, error_d;

  logic                     ready;
  logic                     accept;
  logic                     is_digit, is_term;
  logic [3:0]               char_digit;
  logic [ext_w-1:0]         sum;

  ascii_char_classifier u_classifier (
    .data     (Data_i),
    .is_digit (is_digit),
    .is_term  (is_term),
    .digit    (char_digit)
  );

  assign ready  = (state_q == st_idle) || (state_q == st_discard);
  assign accept = Data_Available_i && ready;
  assign sum    = acc_ext_p1 + ext_w'(digit_p0);

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    digit_p0_d   = digit_p0;
    acc_ext_p1_d = acc_ext_p1;
    value_d      = value_q;
    value_vld_d  = 1'b0;
    error_d      = 1'b0;

    // A strobe while busy is dropped; the number in progress carries on.
    if (Data_Available_i && !ready) begin
      error_d = 1'b1;
    end

    case (state_q)
      // Stage 0: accept a character.
      st_idle: begin
        if (accept) begin
          if (is_digit) begin
            if (count_q == cnt_w'(max_digits_p)) begin
              error_d = 1'b1;
              state_d = st_discard;
            end else begin
              digit_p0_d = char_digit;
              count_d    = count_q + cnt_w'(1);
              state_d    = st_mul;
            end
          end else if (is_term) begin
            // An empty number (e.g. the LF of a CR+LF pair) is ignored.
            if (count_q != '0) begin
              value_d     = acc_q;
              value_vld_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
            end
          end else begin
            error_d = 1'b1;
            state_d = st_discard;
          end
        end
      end
      // Stage 1: scale the running value by ten.
      st_mul: begin
        acc_ext_p1_d = times_ten(acc_q);
        state_d      = st_add;
      end
      // Stage 2: fold in the digit and range-check.
      st_add: begin
        if (exceeds_range(sum)) begin
          error_d = 1'b1;
          state_d = st_discard;
        end else begin
          acc_d   = sum[value_width_p-1:0];
          state_d = st_idle;
        end
      end
      st_discard: begin
        if (accept && is_term) begin
          acc_d   = '0;
          count_d = '0;
          state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q     <= st_idle;
      acc_q       <= '0;
      count_q     <= '0;
      digit_p0    <= '0;
      acc_ext_p1  <= '0;
      value_q     <= '0;
      value_vld_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      digit_p0    <= digit_p0_d;
      acc_ext_p1  <= acc_ext_p1_d;
      value_q     <= value_d;
      value_vld_q <= value_vld_d;
      error_q     <= error_d;
    end
  end

  assign Ready_o           = ready;
  assign Value_o           = value_q;
  assign Value_Available_o = value_vld_q;
  assign Error_o           = error_q;

endmodule

// File: tb/tb_ultrasonic_sensor_ascii_converter.sv
// Directed bench for the ASCII decimal decoder.
module tb_ultrasonic_sensor_ascii_converter;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       Clk_i = 1'b0;
  logic       Reset_i;
  logic [7:0] Data_i;
  logic       Data_Available_i;
  logic       Ready_o;
  logic [8:0] Value_o;
  logic       Value_Available_o;
  logic       Error_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int val_pulses = 0;
  int err_pulses = 0;
  int v0, e0;

  ultrasonic_sensor_ascii_converter dut (
    .Clk_i             (Clk_i),
    .Reset_i           (Reset_i),
    .Data_i            (Data_i),
    .Data_Available_i  (Data_Available_i),
    .Ready_o           (Ready_o),
    .Value_o           (Value_o),
    .Value_Available_o (Value_Available_o),
    .Error_o           (Error_o)
  );

  always #5 Clk_i = ~Clk_i;

  always @(negedge Clk_i) begin
    if (Value_Available_o === 1'b1) val_pulses++;
    if (Error_o === 1'b1) err_pulses++;
  end

  // Strobe one character; returns on the negedge just after the accepting edge.
  task automatic send_char(input logic [7:0] ch);
    @(negedge Clk_i);
    Data_i = ch;
    Data_Available_i = 1'b1;
    @(negedge Clk_i);
    Data_Available_i = 1'b0;
  endtask

  // Digit followed by the two busy cycles, leaving the DUT ready again.
  task automatic send_digit(input logic [7:0] ch);
    send_char(ch);
    repeat (2) @(negedge Clk_i);
  endtask

  task automatic mark;
    #1;
    v0 = val_pulses;
    e0 = err_pulses;
  endtask

  task automatic test_reset;
    Reset_i = 1'b0;
    Data_i = 8'h00;
    Data_Available_i = 1'b0;
    repeat (2) @(negedge Clk_i);
    assert_cnt++; if (Ready_o !== 1'b1) begin fail_cnt++; $display("FAIL reset_ready: got %b expected 1", Ready_o); end
    assert_cnt++; if (Value_o !== 9'd0) begin fail_cnt++; $display("FAIL reset_value: got %0d expected 0", Value_o); end
    assert_cnt++; if (Value_Available_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_vavail: got %b expected 0", Value_Available_o); end
    assert_cnt++; if (Error_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_error: got %b expected 0", Error_o); end
    Reset_i = 1'b1;
    @(negedge Clk_i);
  endtask

  task automatic test_decode_400;
    mark();
    send_digit("4");
    send_digit("0");
    send_digit("0");
    send_char(CR);
    assert_cnt++; if (Value_Available_o !== 1'b1) begin fail_cnt++; $display("FAIL d400_pulse: got %b expected 1", Value_Available_o); end
    assert_cnt++; if (Value_o !== 9'h190) begin fail_cnt++; $display("FAIL d400_value: got %0d expected 400", Value_o); end
    assert_cnt++; if (Ready_o !== 1'b1) begin fail_cnt++; $display("FAIL d400_ready: got %b expected 1", Ready_o); end
    @(negedge Clk_i);
    assert_cnt++; if (Value_Available_o !== 1'b0) begin fail_cnt++; $display("FAIL d400_pulse_width: got %b expected 0", Value_Available_o); end
    #1;
    assert_cnt++; if (val_pulses - v0 !== 1) begin fail_cnt++; $display("FAIL d400_pulse_count: got %0d expected 1", val_pulses - v0); end
    assert_cnt++; if (err_pulses - e0 !== 0) begin fail_cnt++; $display("FAIL d400_errors: got %0d expected 0", err_pulses - e0); end
  endtask

  task automatic test_max_511;
    mark();
    send_digit("5");
    send_digit("1");
    send_digit("1");
    send_char(LF);
    assert_cnt++; if (Value_o !== 9'd511 || Value_Available_o !== 1'b1) begin fail_cnt++; $display("FAIL d511: got %0d/%b expected 511/1", Value_o, Value_Available_o); end
    @(negedge Clk_i); #1;
    assert_cnt++; if (err_pulses - e0 !== 0) begin fail_cnt++; $display("FAIL d511_errors: got %0d expected 0", err_pulses - e0); end
    // Restore 400 as the held value for the overflow check.
    send_digit("4"); send_digit("0"); send_digit("0"); send_char(CR);
  endtask

  task automatic test_overflow_512;
    mark();
    send_digit("5");
    send_digit("1");
    send_char("2");
    assert_cnt++; if (Error_o !== 1'b0) begin fail_cnt++; $display("FAIL ovf_early1: got %b expected 0", Error_o); end
    @(negedge Clk_i);
    assert_cnt++; if (Error_o !== 1'b0) begin fail_cnt++; $display("FAIL ovf_early2: got %b expected 0", Error_o); end
    @(negedge Clk_i);
    assert_cnt++; if (Error_o !== 1'b1) begin fail_cnt++; $display("FAIL ovf_pulse: got %b expected 1", Error_o); end
    send_char(LF);
    assert_cnt++; if (Value_Available_o !== 1'b0) begin fail_cnt++; $display("FAIL ovf_no_value: got %b expected 0", Value_Available_o); end
    assert_cnt++; if (Value_o !== 9'd400) begin fail_cnt++; $display("FAIL ovf_value_held: got %0d expected 400", Value_o); end
    @(negedge Clk_i); #1;
    assert_cnt++; if (val_pulses - v0 !== 0 || err_pulses - e0 !== 1) begin fail_cnt++; $display("FAIL ovf_counts: got v%0d e%0d expected v0 e1", val_pulses - v0, err_pulses - e0); end
  endtask

  task automatic test_digit_limit;
    mark();
    send_digit("1");
    send_digit("2");
    send_digit("3");
    send_char("4");
    assert_cnt++; if (Error_o !== 1'b1) begin fail_cnt++; $display("FAIL lim_error: got %b expected 1", Error_o); end
    assert_cnt++; if (Ready_o !== 1'b1) begin fail_cnt++; $display("FAIL lim_no_mul: got ready %b expected 1", Ready_o); end
    send_char(CR);
    assert_cnt++; if (Value_Available_o !== 1'b0) begin fail_cnt++; $display("FAIL lim_cr_absorbed: got %b expected 0", Value_Available_o); end
    send_digit("7");
    send_char(CR);
    assert_cnt++; if (Value_o !== 9'd7 || Value_Available_o !== 1'b1) begin fail_cnt++; $display("FAIL lim_then_7: got %0d/%b expected 7/1", Value_o, Value_Available_o); end
    @(negedge Clk_i); #1;
    assert_cnt++; if (err_pulses - e0 !== 1) begin fail_cnt++; $display("FAIL lim_err_count: got %0d expected 1", err_pulses - e0); end
  endtask

  task automatic test_leading_zeros;
    mark();
    send_digit("0");
    send_digit("0");
    send_digit("0");
    send_char("5");
    assert_cnt++; if (Error_o !== 1'b1) begin fail_cnt++; $display("FAIL lz_error: got %b expected 1", Error_o); end
    send_char(CR);
    send_digit("0");
    send_digit("0");
    send_digit("9");
    send_char(CR);
    assert_cnt++; if (Value_o !== 9'd9 || Value_Available_o !== 1'b1) begin fail_cnt++; $display("FAIL lz_009: got %0d/%b expected 9/1", Value_o, Value_Available_o); end
  endtask

  task automatic test_illegal;
    mark();
    send_digit("1");
    send_char("A");
    assert_cnt++; if (Error_o !== 1'b1) begin fail_cnt++; $display("FAIL ill_error: got %b expected 1", Error_o); end
    send_char(CR);
    send_char(CR);
    send_char(LF);
    @(negedge Clk_i); #1;
    assert_cnt++; if (err_pulses - e0 !== 1) begin fail_cnt++; $display("FAIL ill_err_count: got %0d expected 1", err_pulses - e0); end
    assert_cnt++; if (val_pulses - v0 !== 0) begin fail_cnt++; $display("FAIL ill_val_count: got %0d expected 0", val_pulses - v0); end
    assert_cnt++; if (Value_o !== 9'd9) begin fail_cnt++; $display("FAIL ill_value_held: got %0d expected 9", Value_o); end
  endtask

  task automatic test_overrun;
    mark();
    send_char("3");
    assert_cnt++; if (Ready_o !== 1'b0) begin fail_cnt++; $display("FAIL ovr_busy: got ready %b expected 0", Ready_o); end
    Data_i = "5";
    Data_Available_i = 1'b1;
    @(negedge Clk_i);
    Data_Available_i = 1'b0;
    assert_cnt++; if (Error_o !== 1'b1) begin fail_cnt++; $display("FAIL ovr_error: got %b expected 1", Error_o); end
    @(negedge Clk_i);
    send_char(CR);
    assert_cnt++; if (Value_o !== 9'd3 || Value_Available_o !== 1'b1) begin fail_cnt++; $display("FAIL ovr_value: got %0d/%b expected 3/1", Value_o, Value_Available_o); end
    @(negedge Clk_i); #1;
    assert_cnt++; if (err_pulses - e0 !== 1) begin fail_cnt++; $display("FAIL ovr_err_count: got %0d expected 1", err_pulses - e0); end
  endtask

  task automatic test_reset_mid_number;
    send_digit("9");
    send_digit("9");
    mark();
    Reset_i = 1'b0;
    #1;
    assert_cnt++; if (Value_o !== 9'd0 || Ready_o !== 1'b1 || Value_Available_o !== 1'b0 || Error_o !== 1'b0)
      begin fail_cnt++; $display("FAIL rst_mid_outputs: got v%0d r%b va%b e%b expected v0 r1 va0 e0", Value_o, Ready_o, Value_Available_o, Error_o); end
    @(negedge Clk_i);
    Reset_i = 1'b1;
    send_digit("3");
    send_char(CR);
    assert_cnt++; if (Value_o !== 9'd3 || Value_Available_o !== 1'b1) begin fail_cnt++; $display("FAIL rst_mid_value: got %0d/%b expected 3/1", Value_o, Value_Available_o); end
    @(negedge Clk_i); #1;
    assert_cnt++; if (val_pulses - v0 !== 1 || err_pulses - e0 !== 0) begin fail_cnt++; $display("FAIL rst_mid_counts: got v%0d e%0d expected v1 e0", val_pulses - v0, err_pulses - e0); end
  endtask

  initial begin
    test_reset();
    test_decode_400();
    test_max_511();
    test_overflow_512();
    test_digit_limit();
    test_leading_zeros();
    test_illegal();
    test_overrun();
    test_reset_mid_number();
    repeat (2) @(negedge Clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ultrasonic_sensor_ascii_converter.md
# ultrasonic_sensor_ascii_converter

Decodes a stream of ASCII decimal characters, such as those received over the UART command link, into a binary integer. It is the inverse of the distance integer-to-ASCII path. The result feeds the threshold and configuration registers of the HC-SR04 subsystem. Arithmetic is done in shift-add form inside the block, with no divider or multiplier IP.

## Interface
Parameters:
- `value_width_p`, default 9: width of the decoded integer (maximum value 511).
- `max_digits_p`, default 3: maximum number of digit characters accepted per number.

Ports:
- `Clk_i`: input, 1 bit. System clock.
- `Reset_i`: input, 1 bit. Asynchronous, active-low reset.
- `Data_i`: input, 8 bits. ASCII character.
- `Data_Available_i`: input, 1 bit. One-cycle strobe indicating `Data_i` is valid.
- `Ready_o`: output, 1 bit. The block accepts a character this cycle.
- `Value_o`: output, `value_width_p` bits. Last successfully decoded integer; held until the next success.
- `Value_Available_o`: output, 1 bit. One-cycle pulse when `Value_o` updates.
- `Error_o`: output, 1 bit. One-cycle pulse when a malformed number, overflow, or overrun occurs.

## Operation
- Character classes:
  - Digit: 0x30–0x39.
  - Terminator: CR 0x0D or LF 0x0A.
  - Anything else is illegal.
- A character is accepted only when `Data_Available_i` and `Ready_o` are both 1.
- State `IDLE` (`Ready_o` = 1):
  - Digit: store digit, increment digit count, go to `MUL`.
  - Terminator with digit count 0: ignored (absorbs CR+LF pairs).
  - Terminator with digit count > 0: load accumulator into `Value_o`, pulse `Value_Available_o`, clear accumulator and count.
  - Illegal character: pulse `Error_o`, go to `DISCARD`.
- State `MUL` (`Ready_o` = 0): `acc_ext <= (acc << 3) + (acc << 1)`, computed in `value_width_p`+4 bits. Next state `ADD`.
- State `ADD` (`Ready_o` = 0): `acc_ext + digit`.
  - If the result exceeds 2^`value_width_p` − 1: pulse `Error_o`, go to `DISCARD`.
  - Otherwise truncate into the accumulator and go to `IDLE`.
- Digit count limit: the (`max_digits_p`+1)th digit pulses `Error_o` in `IDLE` and goes to `DISCARD`; no multiply is performed.
  - Leading zeros count as digits.
- State `DISCARD` (`Ready_o` = 1):
  - Consumes every character until a terminator.
  - On the terminator: clear accumulator and count, go to `IDLE`.
  - No value pulse is produced.
- Overrun: a `Data_Available_i` strobe while `Ready_o` = 0 drops the character and pulses `Error_o`. The number in progress continues unaffected.

## Timing
- Reset values: `Ready_o` = 1, `Value_o` = 0, `Value_Available_o` = 0, `Error_o` = 0. State is `IDLE` with accumulator and count cleared.
- Digit accepted at cycle N:
  - N+1: `MUL`.
  - N+2: `ADD`.
  - N+3: `Ready_o` = 1.
  - Sustained rate is one digit per 3 cycles.
- Terminator accepted at cycle N: `Value_o` and `Value_Available_o` are valid at N+1 (registered outputs). `Ready_o` stays 1.
- `Error_o` timing:
  - Illegal character, digit-count overflow, or overrun at cycle N: pulses at N+1.
  - Arithmetic overflow detected in `ADD` at cycle N+2: pulses at N+3.
- Reset asserted mid-number: immediately returns to the reset values. No pulse is emitted for the partial number.

## Structure
- The shared parameters include file holds:
  - ASCII constants: `ascii_zero_p`, `ascii_nine_p`, `ascii_cr_p`, `ascii_lf_p`.
  - State encodings: `fsm_idle_p`, `fsm_mul_p`, `fsm_add_p`, `fsm_discard_p`.
  - Default values of both parameters.
- Sub-module `ascii_char_classifier`: combinational. Maps `Data_i` to `{is_digit, is_term, digit[3:0]}`.
- The FSM, accumulator, and output registers live in the top module.

## Test plan
- "4","0","0",CR, strobes spaced 3 cycles apart → `Value_o` = 400 (9'h190); `Value_Available_o` pulses once; `Error_o` never asserts.
- "5","1","2",LF → `Error_o` pulses 3 cycles after "2" is accepted (512 > 511); no value pulse; `Value_o` keeps its previous value.
- "1","2","3","4",CR → `Error_o` pulses on "4"; CR is absorbed in `DISCARD`; then "7",CR → `Value_o` = 7 with a pulse.
- "1","A",CR then CR,LF alone → one `Error_o` pulse; no value pulse for the CR/LF-only sequence.
- "3" followed by a strobe one cycle later (`Ready_o` = 0) → `Error_o` pulses and the byte is dropped; then CR → `Value_o` = 3.
- "9","9", reset pulse, then "3",CR → after reset all outputs are 0; `Value_o` = 3, not 993.
